// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: per-register stall/flush,
// PC write/redirect control, and a redirect-pending FSM that never aborts a fetch.
module pipe_ctrl #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  input  logic            i_data_ok,
  input  logic            d_valid,
  input  logic            d_data_ok,
  input  logic            load_use,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            pc_we,
  output logic            pc_redirect,
  output logic [PC_W-1:0] pc_target,
  output logic            commit_valid
);

  typedef enum logic {FETCH, DROP} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              vf_q, vd_q, ve_q, vm_q;
  logic              vf_d, vd_d, ve_d, vm_d;
  logic              dstall, fpend, rd, lu, in_drop;
  logic [3:0]        st, fl;  // raw {F,D,E,M} stall / flush requests

  assign in_drop = (state_q == DROP);
  assign dstall  = d_valid & ~d_data_ok;
  assign fpend   = i_valid & ~i_data_ok;
  assign rd      = redirect & vd_q & ~dstall;
  assign lu      = load_use & vf_q & ~dstall & ~rd;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    st          = '0;
    fl          = '0;
    pc_we       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = redirect_pc;
    state_d     = state_q;
    tgt_d       = tgt_q;

    if (dstall) begin
      st = 4'b1110;
      fl = 4'b0001;
    end else if (rd) begin
      fl[3:2] = 2'b11;
      if (in_drop) begin
        tgt_d = redirect_pc;
      end else if (fpend) begin
        state_d = DROP;
        tgt_d   = redirect_pc;
      end else begin
        pc_we       = 1'b1;
        pc_redirect = 1'b1;
      end
    end else if (lu) begin
      st[3] = 1'b1;
      fl[2] = 1'b1;
    end else if (!in_drop && fpend) begin
      fl[3] = 1'b1;
    end else if (!in_drop) begin
      pc_we = i_valid & i_data_ok;
    end

    // The wrong-path response is discarded; its completion ignores dstall.
    if (in_drop) begin
      if (!dstall) fl[3] = 1'b1;
      if (i_data_ok && !rd) begin
        pc_we       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = tgt_q;
        state_d     = FETCH;
      end
    end

    if (reset) begin
      st          = '0;
      fl          = '1;
      pc_we       = 1'b0;
      pc_redirect = 1'b0;
    end

    {flushF, flushD, flushE, flushM} = fl;
    {stallF, stallD, stallE, stallM} = st & ~fl;

    vf_d = flushF ? 1'b0 : (stallF ? vf_q : (i_valid & i_data_ok & ~in_drop));
    vd_d = flushD ? 1'b0 : (stallD ? vd_q : vf_q);
    ve_d = flushE ? 1'b0 : (stallE ? ve_q : vd_q);
    vm_d = flushM ? 1'b0 : (stallM ? vm_q : ve_q);
  end

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      tgt_q   <= '0;
      vf_q    <= 1'b0;
      vd_q    <= 1'b0;
      ve_q    <= 1'b0;
      vm_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      tgt_q   <= tgt_d;
      vf_q    <= vf_d;
      vd_q    <= vd_d;
      ve_q    <= ve_d;
      vm_q    <= vm_d;
    end
  end

  assign commit_valid = vm_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, fetch stalls, load-use, redirects with and
// without a pending fetch, and dbus stalls holding back a redirect.
module tb_pipe_ctrl;

  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_valid, i_data_ok, d_valid, d_data_ok, load_use, redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            stallF, stallD, stallE, stallM;
  logic            flushF, flushD, flushE, flushM;
  logic            pc_we, pc_redirect, commit_valid;
  logic [PC_W-1:0] pc_target;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_data_ok    (i_data_ok),
    .d_valid      (d_valid),
    .d_data_ok    (d_data_ok),
    .load_use     (load_use),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .stallM       (stallM),
    .flushF       (flushF),
    .flushD       (flushD),
    .flushE       (flushE),
    .flushM       (flushM),
    .pc_we        (pc_we),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .commit_valid (commit_valid)
  );

  always #5 clk = ~clk;

  logic [3:0] stall_v, flush_v;
  assign stall_v = {stallF, stallD, stallE, stallM};
  assign flush_v = {flushF, flushD, flushE, flushM};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then wait to the falling edge to sample.
  task automatic drive(input logic rst, input logic iv, input logic iok, input logic dv,
                       input logic dok, input logic lu, input logic rdr,
                       input logic [PC_W-1:0] pc);
    reset = rst; i_valid = iv; i_data_ok = iok; d_valid = dv; d_data_ok = dok;
    load_use = lu; redirect = rdr; redirect_pc = pc;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // 1: reset with a fetch handshake active, then first-commit latency
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("rst_flush", flush_v, 4'b1111);
      check("rst_stall", stall_v, 4'b0000);
      check("rst_pc_we", pc_we, 1'b0);
      check("rst_commit", commit_valid, 1'b0);
      next_cycle();
    end
    for (int k = 0; k <= 4; k++) begin
      fetch_cycle();
      if (k == 0) begin
        check("first_pc_we", pc_we, 1'b1);
        check("first_flush", flush_v, 4'b0000);
      end
      check("lat_commit", commit_valid, (k == 4));
      next_cycle();
    end

    // 2: ibus response late for 3 cycles; older instructions keep committing
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("fpend_pc_we", pc_we, 1'b0);
      check("fpend_flush", flush_v, 4'b1000);
      check("fpend_stall", stall_v, 4'b0000);
      check("fpend_commit", commit_valid, 1'b1);
      next_cycle();
    end
    // three bubbles drain to commit before the refill arrives
    for (int k = 0; k <= 4; k++) begin
      fetch_cycle();
      check("refill_commit", commit_valid, (k == 0 || k == 4));
      next_cycle();
    end

    // 3: load-use for one cycle inserts exactly one bubble
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("lu_stall", stall_v, 4'b1000);
    check("lu_flush", flush_v, 4'b0100);
    check("lu_pc_we", pc_we, 1'b0);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      fetch_cycle();
      if (k == 1) begin
        check("lu_after_pc_we", pc_we, 1'b1);
        check("lu_after_stall", stall_v, 4'b0000);
      end
      check("lu_commit", commit_valid, (k != 3));
      next_cycle();
    end

    // 4: redirect with the fetch response present
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0100);
    check("rd_pc_redirect", pc_redirect, 1'b1);
    check("rd_pc_target", pc_target, 64'h8000_0100);
    check("rd_pc_we", pc_we, 1'b1);
    check("rd_flush", flush_v, 4'b1100);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      fetch_cycle();
      if (k == 1) check("rd_after_redirect", pc_redirect, 1'b0);
      check("rd_commit", commit_valid, (k <= 2));
      next_cycle();
    end

    // 5: redirect while a fetch is outstanding -> DROP until the response lands
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0200);
    check("drop_enter_pc_we", pc_we, 1'b0);
    check("drop_enter_redirect", pc_redirect, 1'b0);
    check("drop_enter_flush", flush_v, 4'b1100);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("drop_wait_pc_we", pc_we, 1'b0);
    check("drop_wait_flush", flush_v, 4'b1000);
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("drop_done_flushF", flushF, 1'b1);
    check("drop_done_pc_we", pc_we, 1'b1);
    check("drop_done_redirect", pc_redirect, 1'b1);
    check("drop_done_target", pc_target, 64'h8000_0200);
    next_cycle();
    for (int k = 3; k <= 7; k++) begin
      fetch_cycle();
      if (k == 3) check("drop_back_redirect", pc_redirect, 1'b0);
      if (k == 6) check("drop_no_commit", commit_valid, 1'b0);
      if (k == 7) check("drop_target_commit", commit_valid, 1'b1);
      next_cycle();
    end

    // 6: dbus stall holds back a redirect until d_data_ok
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0300);
      check("dstall_stall", stall_v, 4'b1110);
      check("dstall_flush", flush_v, 4'b0001);
      check("dstall_redirect", pc_redirect, 1'b0);
      check("dstall_pc_we", pc_we, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0300);
    check("dok_redirect", pc_redirect, 1'b1);
    check("dok_target", pc_target, 64'h8000_0300);
    check("dok_flush", flush_v, 4'b1100);
    check("dok_stall", stall_v, 4'b0000);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
